encoder_nbit_seq: RTL

- Reverse direction of the team's n-bit decoder: converts 2**N request lines back into an N-bit binary index.
- Request pulses are latched into a pending register, then emitted one index at a time, highest priority first, over a valid/ready handshake.
- Sits between event sources (one-hot or multi-hot pulses) and a consumer that handles one encoded event per transfer. Its output can drive a decoder_nbit instance directly.

---
 rtl/encoder_pkg.sv | 27 ++
 rtl/encoder_nbit_seq_prio.sv | 37 +++
 rtl/encoder_nbit_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the n-bit sequential encoder.
// The optional round-robin priority is enabled by defining ENCODER_ROTATE_PRIO_EN.
package encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } enc_state_e;

    localparam int DEFAULT_N = 3;
    localparam int MAX_N     = 8;
    localparam int MAX_W     = 2**MAX_N;

    // Width of the request vector for an index width of n.
    function automatic int req_width(input int n);
        return 2**n;
    endfunction

    // One-hot vector for idx, sized for the largest supported N; callers keep the low W bits.
    function automatic logic [MAX_W-1:0] onehot_of(input logic [MAX_N-1:0] idx);
        logic [MAX_W-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/encoder_nbit_seq_prio.sv
// Combinational priority finder: searches downward from start_i, wrapping from 0 to 2**N-1.
module prio_find_nbit
    import encoder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [2**N-1:0] vec_i,
    input  logic [N-1:0]    start_i,
    output logic            found_o,
    output logic [N-1:0]    idx_o
);

    localparam int W = req_width(N);

    // cand[k] is the bit k steps below start_i, so the lowest set k is the winner.
    logic [W-1:0] cand;
    logic [N-1:0] off;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_rot
            assign cand[gi] = vec_i[start_i - N'(gi)];
        end
    endgenerate

    always_comb begin
        found_o = 1'b0;
        off     = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (cand[k]) begin
                found_o = 1'b1;
                off     = N'(k);
            end
        end
        idx_o = start_i - off;
    end

endmodule

// File: rtl/encoder_nbit_seq.sv
// Latches multi-hot request pulses and emits their indices one per valid/ready transfer.
// Define ENCODER_ROTATE_PRIO_EN for round-robin priority; default is fixed highest-index-first.
module encoder_nbit_seq
    import encoder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [2**N-1:0] req,
    output logic [N-1:0]    y,
    output logic            valid,
    input  logic            ready,
    output logic [2**N-1:0] pending,
    output logic            overflow
);

    localparam int W = req_width(N);

    enc_state_e   state_q, state_d;
    logic [W-1:0] pending_q, pending_d;
    logic [N-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic         overflow_q, overflow_d;

    logic [W-1:0]     set_mask;
    logic [W-1:0]     grant_mask;
    logic [MAX_W-1:0] oh_wide;
    logic             grant;
    logic             found;
    logic [N-1:0]     win;
    logic [N-1:0]     search_start;

`ifdef ENCODER_ROTATE_PRIO_EN
    logic [N-1:0] last_idx_q, last_idx_d;
    logic         armed_q, armed_d;

    // Until the first grant the search starts at the top, so the first order matches the fixed build.
    assign search_start = armed_q ? (last_idx_q - N'(1)) : N'(W - 1);
    assign last_idx_d   = grant ? win : last_idx_q;
    assign armed_d      = armed_q | grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx_q <= N'(W - 1);
            armed_q    <= 1'b0;
        end else begin
            last_idx_q <= last_idx_d;
            armed_q    <= armed_d;
        end
    end
`else
    assign search_start = N'(W - 1);
`endif

    prio_find_nbit #(.N(N)) u_prio (
        .vec_i   (pending_q),
        .start_i (search_start),
        .found_o (found),
        .idx_o   (win)
    );

    assign oh_wide = onehot_of(MAX_N'(win));

    generate
        if (W < MAX_W) begin : g_oh_hi
            logic unused_oh_hi;
            assign unused_oh_hi = |oh_wide[MAX_W-1:W];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        valid_d = valid_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    y_d     = win;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (found) begin
                        grant = 1'b1;
                        y_d   = win;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A bit granted and requested in the same cycle stays pending as a new event.
        grant_mask = grant ? oh_wide[W-1:0] : '0;
        set_mask   = enable ? req : '0;
        pending_d  = (pending_q & ~grant_mask) | set_mask;
        overflow_d = overflow_q | (|(set_mask & pending_q & ~grant_mask));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            y_q        <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign y        = y_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule
